// File: rtl/regfile_pkg.sv
//------------------------------------------------------------------------------
// Module   : regfile_pkg
// Purpose  : Shared register-file constants, address type and write-stage states.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int DATA_W   = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
//------------------------------------------------------------------------------
// Module   : rr_arbiter
// Purpose  : Combinational round-robin arbiter; first request at or after ptr wins.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic                    en,
    input  logic [$clog2(NREQ)-1:0] ptr,
    output logic [NREQ-1:0]         gnt,
    output logic [$clog2(NREQ)-1:0] gnt_idx
);

    localparam int c_idx_w = $clog2(NREQ);

    int                 w_idx;
    logic [c_idx_w-1:0] w_sel;
    logic               w_found;

    // Modulo walk keeps the wrap correct when NREQ is not a power of two.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = (int'(ptr) + i) % NREQ;
            w_sel = c_idx_w'(w_idx);
            if (en && !w_found && req[w_sel]) begin
                gnt[w_sel] = 1'b1;
                gnt_idx    = w_sel;
                w_found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wr_sched.sv
//------------------------------------------------------------------------------
// Module   : regfile_wr_sched
// Purpose  : Round-robin write-port scheduler with one-entry output stage,
//            pending-write decode and r0 drop counter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module regfile_wr_sched #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W,
    parameter bit ZERO_RO = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic                     wr_valid,
    input  logic                     wr_ready,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [(2**ADDR_W)-1:0]   pending,
    output logic [7:0]               drop_cnt
);

    import regfile_pkg::*;

    localparam int         c_idx_w    = $clog2(NREQ);
    localparam int         c_num_regs = 2 ** ADDR_W;
    localparam logic [7:0] c_drop_max = 8'hFF;

    stage_state_e        r_state;
    stage_state_e        w_state_nxt;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_idx_w-1:0]  w_gnt_idx;
    logic [c_idx_w-1:0]  w_ptr_nxt;
    logic [NREQ-1:0]     w_gnt;
    logic                w_can_accept;
    logic                w_accept;
    logic                w_is_zero;
    logic                w_load;
    logic                w_wr_valid;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic [DATA_W-1:0]   w_acc_data;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [7:0]          r_drop_cnt;

    assign w_wr_valid   = (r_state == ST_FULL);
    assign w_can_accept = ~w_wr_valid | wr_ready;

    // Gating with rst_n keeps req_ready low for the whole reset pulse.
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req     (req_valid),
        .en      (w_can_accept & rst_n),
        .ptr     (r_rr_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_accept   = |w_gnt;
    assign w_acc_addr = req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
    assign w_acc_data = req_data[w_gnt_idx*DATA_W +: DATA_W];
    assign w_is_zero  = ZERO_RO && (w_acc_addr == ADDR_W'(REG_ZERO));
    assign w_load     = w_accept & ~w_is_zero;
    assign w_ptr_nxt  = (w_gnt_idx == c_idx_w'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_load)                w_state_nxt = ST_FULL;
            ST_FULL:  if (wr_ready && !w_load)   w_state_nxt = ST_EMPTY;
            default:                             w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_rr_ptr   <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rr_ptr <= w_ptr_nxt;
            end
            if (w_load) begin
                r_wr_addr <= w_acc_addr;
                r_wr_data <= w_acc_data;
            end
            if (w_accept && w_is_zero && (r_drop_cnt != c_drop_max)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    for (genvar gi = 0; gi < c_num_regs; gi++) begin : g_pending
        assign pending[gi] = w_wr_valid && (r_wr_addr == ADDR_W'(gi));
    end

    assign req_ready = w_gnt;
    assign wr_valid  = w_wr_valid;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign drop_cnt  = r_drop_cnt;

endmodule

`default_nettype wire
